// File: rtl/score_bcd_display_pkg.sv
// Shared constants and types for the score BCD display: segment patterns
// (active-low {g,f,e,d,c,b,a}) and the conversion FSM state encoding.
package score_bcd_display_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

endpackage

// File: rtl/score_bcd_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10-15 never reach this decoder in normal use and map to all-off.
module bcd_to_seg7
   import score_bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Digit pattern lookup.
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_bcd_display.sv
// Binary score to multiplexed seven-segment display: a double-dabble converter
// commits all digits atomically while a free-running scanner drives an/seg.
module score_bcd_display
   import score_bcd_display_pkg::*;
#(
   parameter int BIN_W       = 14,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] score,
   input  logic             load,
   input  logic             blank_lz,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [7:0]       an,
   output logic [6:0]       seg
);

   localparam int         BCD_W   = DIGITS * 4;
   localparam int         WORK_W  = BCD_W + BIN_W;
   localparam int         CNT_W   = 5;
   localparam int         DIV_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [31:0] MAX_VAL = 32'(10**DIGITS - 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [2:0]       IDX_LAST  = 3'(DIGITS - 1);

   state_t             state_r;
   state_t             state_nx_s;
   logic               accept_s;
   logic [CNT_W-1:0]   iter_r;
   logic [WORK_W-1:0]  work_r;
   logic [WORK_W-1:0]  adj_s;
   logic [BCD_W-1:0]   disp_r;
   logic               busy_r;
   logic               done_r;
   logic               overflow_r;
   logic               ovf_s;
   logic [BIN_W-1:0]   cap_s;
   logic [DIV_W-1:0]   div_r;
   logic [2:0]         idx_r;
   logic [3:0]         sel_s;
   logic               blank_s;
   logic [6:0]         dec_s;
   logic [7:0]         an_r;
   logic [6:0]         seg_r;

   // Saturate out-of-range scores to all nines so every digit stays 0-9.
   assign ovf_s = (32'(score) > MAX_VAL);
   assign cap_s = ovf_s ? MAX_VAL[BIN_W-1:0] : score;

   // FSM next-state logic; a load is accepted only from IDLE.
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (load) begin
               state_nx_s = ST_CONVERT;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_CONVERT: begin
            if (iter_r == LAST_ITER) begin
               state_nx_s = ST_COMMIT;
            end else begin
               state_nx_s = ST_CONVERT;
            end
         end
         ST_COMMIT: state_nx_s = ST_IDLE;
         default:   state_nx_s = ST_IDLE;
      endcase
   end

   // Add-3 correction on each BCD nibble ahead of the shift.
   always_comb begin
      adj_s = work_r;
      for (int d = 0; d < DIGITS; d++) begin
         adj_s[BIN_W + 4*d +: 4] = (work_r[BIN_W + 4*d +: 4] >= 4'd5) ?
                                   (work_r[BIN_W + 4*d +: 4] + 4'd3) :
                                   work_r[BIN_W + 4*d +: 4];
      end
   end

   // FSM state, converter datapath and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         iter_r     <= '0;
         work_r     <= '0;
         disp_r     <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s != ST_IDLE);
         done_r  <= (state_r == ST_COMMIT);
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  work_r     <= {{BCD_W{1'b0}}, cap_s};
                  overflow_r <= ovf_s;
                  iter_r     <= '0;
               end
            end
            ST_CONVERT: begin
               work_r <= {adj_s[WORK_W-2:0], 1'b0};
               iter_r <= iter_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            ST_COMMIT: disp_r <= work_r[WORK_W-1 -: BCD_W];
            default:   disp_r <= disp_r;
         endcase
      end
   end

   // Refresh divider and digit index; free-running, independent of the converter.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_r <= '0;
         idx_r <= 3'd0;
      end else if (div_r == DIV_LAST) begin
         div_r <= '0;
         idx_r <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
      end else begin
         div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

   // Digit multiplexer with leading-zero detection scanned from the top digit down.
   always_comb begin
      logic zero_run;
      sel_s    = 4'd0;
      blank_s  = 1'b0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (disp_r[4*i +: 4] == 4'd0);
         sel_s    = (idx_r == 3'(i)) ? disp_r[4*i +: 4] : sel_s;
         blank_s  = (idx_r == 3'(i)) ? (blank_lz & zero_run & (i != 0)) : blank_s;
      end
   end

   bcd_to_seg7 u_dec (
      .bcd (sel_s),
      .seg (dec_s)
   );

   // Registered digit enable and segment drive, both one cycle behind idx_r.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_r  <= 8'hFF;
         seg_r <= SEG_BLANK;
      end else begin
         an_r  <= ~(8'd1 << idx_r);
         seg_r <= blank_s ? SEG_BLANK : dec_s;
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign overflow = overflow_r;
   assign an       = an_r;
   assign seg      = seg_r;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed self-checking bench for score_bcd_display (BIN_W=14, DIGITS=4, REFRESH_DIV=4).
module tb_score_bcd_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] score;
   logic        load;
   logic        blank_lz;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [7:0]  an;
   logic [6:0]  seg;

   int checks = 0;
   int errors = 0;

   score_bcd_display #(.BIN_W(14), .DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .score    (score),
      .load     (load),
      .blank_lz (blank_lz),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .an       (an),
      .seg      (seg)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one load and verify busy, latency BIN_W+1, one-cycle done and overflow.
   task automatic do_convert(input logic [13:0] val, input logic exp_ovf);
      int lat;
      lat   = 0;
      score = val;
      load  = 1'b1;
      step();
      load  = 1'b0;
      check("busy_after_accept", 32'(busy), 32'(1'b1));
      for (int c = 1; c <= 30; c++) begin
         step();
         if (c == 14) check("busy_before_done", 32'(busy), 32'(1'b1));
         if (done) begin
            lat = c;
            break;
         end
      end
      check("done_latency", 32'(lat), 32'd15);
      check("busy_at_done", 32'(busy), 32'(1'b0));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      step();
      check("done_one_cycle", 32'(done), 32'(1'b0));
   endtask

   // Lock onto the an=FE boundary, then check 4-cycle holds and per-digit segments.
   task automatic check_display(input logic [6:0] e0, input logic [6:0] e1,
                                input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] es [4];
      logic [7:0] ap [4];
      logic [7:0] prev;
      logic       found;
      es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
      ap[0] = 8'hFE; ap[1] = 8'hFD; ap[2] = 8'hFB; ap[3] = 8'hF7;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         prev = an;
         step();
         if (an == 8'hFE && prev != 8'hFE) begin
            found = 1'b1;
            break;
         end
      end
      check("scan_sync", 32'(found), 32'(1'b1));
      for (int k = 0; k < 16; k++) begin
         check($sformatf("an_k%0d", k), 32'(an), 32'(ap[k/4]));
         check($sformatf("seg_k%0d", k), 32'(seg), 32'(es[k/4]));
         step();
      end
      check("an_wrap", 32'(an), 32'(8'hFE));
   endtask

   initial begin
      int nd;
      int dc;
      rst      = 1'b1;
      load     = 1'b1;
      score    = 14'd1234;
      blank_lz = 1'b0;
      step();
      step();
      check("rst_an", 32'(an), 32'(8'hFF));
      check("rst_seg", 32'(seg), 32'(7'h7F));
      check("rst_busy", 32'(busy), 32'(1'b0));
      check("rst_done", 32'(done), 32'(1'b0));
      check("rst_overflow", 32'(overflow), 32'(1'b0));
      rst  = 1'b0;
      load = 1'b0;
      step();
      check("idle_busy", 32'(busy), 32'(1'b0));
      check_display(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

      do_convert(14'd1234, 1'b0);
      check_display(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

      do_convert(14'd16383, 1'b1);
      check_display(7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);
      do_convert(14'd42, 1'b0);
      check_display(7'b0100100, 7'b0011001, 7'b1000000, 7'b1000000);

      blank_lz = 1'b1;
      check_display(7'b0100100, 7'b0011001, 7'h7F, 7'h7F);
      do_convert(14'd7, 1'b0);
      check_display(7'b1111000, 7'h7F, 7'h7F, 7'h7F);
      do_convert(14'd0, 1'b0);
      check_display(7'b1000000, 7'h7F, 7'h7F, 7'h7F);
      do_convert(14'd1004, 1'b0);
      check_display(7'b0011001, 7'b1000000, 7'b1000000, 7'b1111001);
      blank_lz = 1'b0;

      // Load during conversion is dropped, not queued.
      score = 14'd905;
      load  = 1'b1;
      step();
      nd = 0;
      dc = 0;
      for (int c = 1; c <= 30; c++) begin
         if (c == 3) begin
            load  = 1'b1;
            score = 14'd8888;
         end else begin
            load = 1'b0;
         end
         step();
         if (done) begin
            nd++;
            dc = c;
         end
      end
      check("ignored_load_done_count", 32'(nd), 32'd1);
      check("ignored_load_done_cycle", 32'(dc), 32'd15);
      check_display(7'b0010010, 7'b1000000, 7'b0010000, 7'b1000000);

      // Reset mid-conversion aborts it and zeroes the digits.
      score = 14'd1234;
      load  = 1'b1;
      step();
      load = 1'b0;
      nd   = 0;
      for (int c = 1; c <= 25; c++) begin
         rst = (c == 5);
         step();
         if (done) nd++;
         if (c == 5) begin
            check("abort_busy", 32'(busy), 32'(1'b0));
            check("abort_an", 32'(an), 32'(8'hFF));
         end
      end
      rst = 1'b0;
      check("abort_no_done", 32'(nd), 32'd0);
      check_display(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
      do_convert(14'd56, 1'b0);
      check_display(7'b0000010, 7'b0010010, 7'b1000000, 7'b1000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_bcd_display.md
SCORE_BCD_DISPLAY -- requirements
Module: score_bcd_display

Interface
REQ-001 Parameter BIN_W, default 14, width of the binary score input (1..27).
REQ-002 Parameter DIGITS, default 4, number of displayed decimal digits (1..8).
REQ-003 Parameter REFRESH_DIV, default 100000, clock cycles each digit is driven before the scan advances (>=1).
REQ-004 clk  input  1  the single clock; all logic is rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 score  input  BIN_W  unsigned binary value, sampled only on an accepted load.
REQ-007 load  input  1  request to convert score; one-cycle pulse or level.
REQ-008 blank_lz  input  1  when 1, leading zeros are blanked.
REQ-009 busy  output  1  conversion in progress.
REQ-010 done  output  1  one-cycle pulse when new digits become visible.
REQ-011 overflow  output  1  the last accepted score exceeded 10^DIGITS-1.
REQ-012 an  output  8  active-low digit enables; bit i selects digit i (0 = least significant).
REQ-013 seg  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.

Function
REQ-014 Load is accepted when load=1 and busy=0; load while busy=1 shall be ignored without being queued.
REQ-015 On acceptance, capture score; if score > 10^DIGITS-1, substitute 10^DIGITS-1 (all nines) and set overflow=1, else clear overflow.
REQ-016 States: IDLE, CONVERT, COMMIT; IDLE->CONVERT on accept; CONVERT runs exactly BIN_W shift-add-3 (double-dabble) iterations, one per cycle; CONVERT->COMMIT after the last iteration; COMMIT->IDLE unconditionally.
REQ-017 busy shall be 1 in CONVERT and COMMIT, and 0 in IDLE.
REQ-018 In COMMIT, all DIGITS display digits shall update in the same cycle; the displayed value never mixes old and new digits.
REQ-019 done shall be 1 during the cycle in which the new digits first appear; latency from accepting edge t to done is BIN_W+1 cycles.
REQ-020 A load may be accepted in the cycle after COMMIT (back-to-back throughput of BIN_W+2 cycles).
REQ-021 The BCD working register shall be DIGITS*4 bits plus BIN_W bits; no add-3 correction shall overflow out of a digit.
REQ-022 Scan: a divider counts 0..REFRESH_DIV-1; on wrap, the digit index increments and wraps from DIGITS-1 to 0.
REQ-023 an[idx]=0 and all other bits are 1; bits DIGITS..7 are always 1.
REQ-024 seg decodes the selected digit 0-9 (standard patterns); codes 10-15 cannot occur and shall drive 7'h7F.
REQ-025 Leading-zero blanking: digit i>0 shall drive seg=7'h7F when blank_lz=1 and digits i..DIGITS-1 are all zero; digit 0 is never blanked.
REQ-026 an and seg are registered; they lag the index by one cycle, and the lag is consistent for both.
REQ-027 Scanning runs continuously and is unaffected by conversion activity.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, busy=0, done=0, overflow=0, all digits=0, divider=0, index=0, an=8'hFF, seg=7'h7F.
REQ-029 Reset during CONVERT or COMMIT aborts the conversion; no done pulse is produced and the digits read 0.
REQ-030 rst has priority over a simultaneous load.

Structure
REQ-031 The shared package holds MAX_DIGITS=8, the ten 7-bit segment constants, SEG_BLANK=7'h7F and the state typedef.
REQ-032 One sub-module, bcd_to_seg7 (combinational, 4-bit in, 7-bit out), is instantiated once after the digit multiplexer.

Verification (BIN_W=14, DIGITS=4, REFRESH_DIV=4)
REQ-033 Reset -> an=8'hFF, seg=7'h7F, busy=0, done=0, overflow=0.
REQ-034 load, score=1234 at edge t -> busy=1 from t+1; done=1 only at t+15; digits 4,3,2,1; while an=8'hFE, seg=7'b0011001; each an value holds 4 cycles, in the sequence FE, FD, FB, F7, FE.
REQ-035 score=16383 -> overflow=1, all digits 9; then score=42 -> overflow=0.
REQ-036 blank_lz=1, score=7 -> digits 3..1 drive 7'h7F, digit 0 drives 7'b1111000; score=0 -> only digit 0 lit, showing 7'b1000000.
REQ-037 load pulses at t+3 during a conversion -> ignored, exactly one done; rst at t+5 -> no done, digits 0, next load converts normally.
